// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: default sizing and the
// 2-bit FSM state encoding.
package uart_tx_arbiter_pkg;

    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_BUSY_TIMEOUT = 4;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted request strictly after
// rr_ptr, wrapping modulo NUM_REQ.
module rr_select
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned W       = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [W-1:0]       rr_ptr,
    output logic [W-1:0]       winner,
    output logic               any_req
);

    logic [31:0]  idx;
    logic [W-1:0] cand;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        cand    = '0;
        // Scan offsets 1..NUM_REQ so the last winner is considered last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx  = (32'(rr_ptr) + i) % NUM_REQ;
            cand = idx[W-1:0];
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from NUM_REQ requesters into one
// UART transmitter, with a sticky error if the transmitter never goes busy.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int unsigned W  = $clog2(NUM_REQ);
    localparam int unsigned CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    logic [1:0]         state_q, state_d;
    logic               tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [W-1:0]       grant_id_q, grant_id_d;
    logic [W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               active_q, active_d;
    logic               timeout_err_q, timeout_err_d;

    logic [W-1:0]       winner;
    logic               any_req;
    logic [7:0]         sel_data;
    logic [NUM_REQ-1:0] sel_onehot;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .W       (W)
    ) u_rr_select (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        sel_data   = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (W'(i) == winner) begin
                sel_data      = req_data[8*i +: 8];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_start_d    = 1'b0;
        req_ready_d   = '0;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                // Outputs are registered, so the ISSUE-cycle pulses are set here.
                if (any_req && !tx_busy) begin
                    state_d     = ST_ISSUE;
                    tx_start_d  = 1'b1;
                    req_ready_d = sel_onehot;
                    tx_data_d   = sel_data;
                    grant_id_d  = winner;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = grant_id_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_id_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tx_start_q    <= 1'b0;
            req_ready_q   <= '0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            rr_ptr_q      <= W'(NUM_REQ - 1);
            cnt_q         <= '0;
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_start_q    <= tx_start_d;
            req_ready_q   <= req_ready_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued as
// requests are driven and compared at each tx_start.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    logic        model_en;
    logic        model_busy;
    logic        man_busy;
    int          busy_len;

    typedef struct {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    assign tx_busy = model_en ? model_busy : man_busy;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter model: goes busy on the tx_start cycle for busy_len cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && tx_start) begin
                model_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [7:0] d, input logic [1:0] id);
        exp_t e;
        e.data = d;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(input int max_cyc, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            seen = (tx_start === 1'b1);
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            ok = (active === 1'b0);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (active !== 1'b0 || tx_start !== 1'b0) begin n_err++; $display("FAIL reset_idle_after_release: active=%b tx_start=%b want 0/0", active, tx_start); end
    endtask

    task automatic test_single();
        exp_t e; bit seen; int cyc; bit ok;
        model_en = 1'b1;
        busy_len = 3;
        req_data[7:0] = 8'h55;
        req_valid = 4'b0001;
        push_exp(8'h55, 2'd0);
        wait_start(10, seen, cyc);
        e = exp_q.pop_front();
        req_valid = 4'b0000;
        n_vec++; if (!seen || cyc != 1) begin n_err++; $display("FAIL single_latency: got %0d cycles (seen=%0b) want 1", cyc, seen); end
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_req_ready: got %b want 0001", req_ready); end
        n_vec++; if (tx_data !== e.data) begin n_err++; $display("FAIL single_tx_data: got %h want %h", tx_data, e.data); end
        n_vec++; if (grant_id !== e.id) begin n_err++; $display("FAIL single_grant_id: got %0d want %0d", grant_id, e.id); end
        @(negedge clk);
        n_vec++; if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL single_pulse_width: tx_start=%b req_ready=%b want 0/0000", tx_start, req_ready); end
        wait_idle(20, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_return_idle: active=%b want 0", active); end
        n_vec++; if (tx_data !== 8'h55) begin n_err++; $display("FAIL single_data_hold: got %h want 55", tx_data); end
    endtask

    task automatic test_contention();
        exp_t e; bit seen; int cyc; bit ok;
        apply_reset();
        model_en = 1'b1;
        busy_len = 100;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req_valid = 4'b1111;
        push_exp(8'h10, 2'd0);
        push_exp(8'h21, 2'd1);
        push_exp(8'h32, 2'd2);
        push_exp(8'h43, 2'd3);
        for (int k = 0; k < 4; k++) begin
            wait_start((k == 0) ? 10 : 300, seen, cyc);
            e = exp_q.pop_front();
            n_vec++; if (!seen || cyc != ((k == 0) ? 1 : 102)) begin n_err++; $display("FAIL contend_spacing[%0d]: got %0d cycles (seen=%0b) want %0d", k, cyc, seen, (k == 0) ? 1 : 102); end
            n_vec++; if (grant_id !== e.id) begin n_err++; $display("FAIL contend_grant[%0d]: got %0d want %0d", k, grant_id, e.id); end
            n_vec++; if (tx_data !== e.data) begin n_err++; $display("FAIL contend_data[%0d]: got %h want %h", k, tx_data, e.data); end
            n_vec++; if (req_ready !== (4'b0001 << e.id)) begin n_err++; $display("FAIL contend_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << e.id); end
            req_valid[e.id] = 1'b0;
        end
        wait_idle(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL contend_return_idle: active=%b want 0", active); end
    endtask

    task automatic test_fairness();
        exp_t e; bit seen; int cyc; bit ok;
        model_en = 1'b1;
        busy_len = 5;
        req_data = {8'hA3, 8'h00, 8'h00, 8'hA0};
        req_valid = 4'b1001;
        push_exp(8'hA0, 2'd0);
        push_exp(8'hA3, 2'd3);
        push_exp(8'hA0, 2'd0);
        push_exp(8'hA3, 2'd3);
        for (int k = 0; k < 4; k++) begin
            wait_start((k == 0) ? 10 : 30, seen, cyc);
            e = exp_q.pop_front();
            n_vec++; if (!seen || cyc != ((k == 0) ? 1 : 7)) begin n_err++; $display("FAIL fair_spacing[%0d]: got %0d cycles (seen=%0b) want %0d", k, cyc, seen, (k == 0) ? 1 : 7); end
            n_vec++; if (grant_id !== e.id || tx_data !== e.data) begin n_err++; $display("FAIL fair_grant[%0d]: got id %0d data %h want id %0d data %h", k, grant_id, tx_data, e.id, e.data); end
        end
        req_valid = 4'b0000;
        wait_idle(30, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL fair_return_idle: active=%b want 0", active); end
    endtask

    task automatic test_foreign_busy();
        exp_t e; bit seen; int cyc; bit ok;
        model_en = 1'b0;
        man_busy = 1'b1;
        req_data[15:8] = 8'h3C;
        req_valid = 4'b0010;
        push_exp(8'h3C, 2'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_vec++; if (tx_start !== 1'b0 || active !== 1'b0) begin n_err++; $display("FAIL foreign_hold[%0d]: tx_start=%b active=%b want 0/0", k, tx_start, active); end
        end
        man_busy = 1'b0;
        wait_start(10, seen, cyc);
        e = exp_q.pop_front();
        req_valid = 4'b0000;
        man_busy = 1'b1;
        n_vec++; if (!seen || cyc != 1) begin n_err++; $display("FAIL foreign_release_latency: got %0d cycles (seen=%0b) want 1", cyc, seen); end
        n_vec++; if (grant_id !== e.id || tx_data !== e.data) begin n_err++; $display("FAIL foreign_grant: got id %0d data %h want id %0d data %h", grant_id, tx_data, e.id, e.data); end
        repeat (3) @(negedge clk);
        man_busy = 1'b0;
        wait_idle(10, ok);
        n_vec++; if (!ok || timeout_err !== 1'b0) begin n_err++; $display("FAIL foreign_complete: idle=%0b timeout_err=%b want 1/0", ok, timeout_err); end
    endtask

    task automatic test_timeout();
        exp_t e; bit seen; int cyc; bit ok;
        model_en = 1'b0;
        man_busy = 1'b0;
        req_data[15:0] = {8'h61, 8'h60};
        req_valid = 4'b0011;
        push_exp(8'h60, 2'd0);
        push_exp(8'h61, 2'd1);
        wait_start(10, seen, cyc);
        e = exp_q.pop_front();
        n_vec++; if (!seen || cyc != 1 || grant_id !== e.id || tx_data !== e.data) begin n_err++; $display("FAIL timeout_first_grant: seen=%0b cyc=%0d id %0d data %h want cyc 1 id %0d data %h", seen, cyc, grant_id, tx_data, e.id, e.data); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_vec++; if (timeout_err !== 1'b0 || active !== 1'b1) begin n_err++; $display("FAIL timeout_early[%0d]: timeout_err=%b active=%b want 0/1", k, timeout_err, active); end
        end
        @(negedge clk);
        n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", timeout_err); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL timeout_to_idle: active=%b want 0", active); end
        wait_start(10, seen, cyc);
        e = exp_q.pop_front();
        req_valid = 4'b0000;
        n_vec++; if (!seen || cyc != 1 || grant_id !== e.id || tx_data !== e.data) begin n_err++; $display("FAIL timeout_next_grant: seen=%0b cyc=%0d id %0d data %h want cyc 1 id %0d data %h", seen, cyc, grant_id, tx_data, e.id, e.data); end
        wait_idle(20, ok);
        n_vec++; if (!ok || timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: idle=%0b timeout_err=%b want 1/1", ok, timeout_err); end
    endtask

    task automatic test_reset_mid();
        exp_t e; bit seen; int cyc; bit ok;
        model_en = 1'b1;
        busy_len = 100;
        req_data[23:16] = 8'h99;
        req_valid = 4'b0100;
        push_exp(8'h99, 2'd2);
        wait_start(10, seen, cyc);
        e = exp_q.pop_front();
        req_valid = 4'b0000;
        n_vec++; if (!seen || grant_id !== e.id || tx_data !== e.data) begin n_err++; $display("FAIL midrst_grant: seen=%0b id %0d data %h want id %0d data %h", seen, grant_id, tx_data, e.id, e.data); end
        repeat (10) @(negedge clk);
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL midrst_in_transfer: active=%b want 1", active); end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_pulses: tx_start=%b req_ready=%b want 0/0000", tx_start, req_ready); end
        n_vec++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin n_err++; $display("FAIL midrst_data_grant: tx_data=%h grant_id=%0d want 00/0", tx_data, grant_id); end
        n_vec++; if (active !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL midrst_flags: active=%b timeout_err=%b want 0/0", active, timeout_err); end
        model_en = 1'b0;
        man_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        req_valid = 4'b1111;
        push_exp(8'hD0, 2'd0);
        wait_start(10, seen, cyc);
        e = exp_q.pop_front();
        req_valid = 4'b0000;
        n_vec++; if (!seen || cyc != 1 || grant_id !== e.id || tx_data !== e.data) begin n_err++; $display("FAIL midrst_first_winner: seen=%0b cyc=%0d id %0d data %h want cyc 1 id %0d data %h", seen, cyc, grant_id, tx_data, e.id, e.data); end
        wait_idle(20, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL midrst_return_idle: active=%b want 0", active); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        man_busy  = 1'b0;
        model_en  = 1'b0;
        busy_len  = 0;

        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_foreign_busy();
        test_timeout();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters; legal range 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 4, max cycles between tx_start and tx_busy rising.
REQ-003 Port clk, input, 1, the single system clock; all logic on rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port req_valid, input, NUM_REQ, per-requester byte-pending flag; held high with data stable until accepted.
REQ-006 Port req_data, input, 8*NUM_REQ, packed bytes; requester i in bits [8i+7:8i].
REQ-007 Port req_ready, output, NUM_REQ, one-hot accept pulse.
REQ-008 Port tx_start, output, 1, one-cycle start pulse to the UART transmitter.
REQ-009 Port tx_data, output, 8, byte presented to the transmitter.
REQ-010 Port tx_busy, input, 1, transmitter busy flag.
REQ-011 Port grant_id, output, clog2(NUM_REQ), index of the current or last granted requester.
REQ-012 Port active, output, 1, high in every state except IDLE.
REQ-013 Port timeout_err, output, 1, sticky flag; tx_busy failed to rise within BUSY_TIMEOUT.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-015 IDLE: when any req_valid is high and tx_busy is low, the block SHALL select one requester round-robin, starting from rr_ptr+1 and wrapping modulo NUM_REQ.
REQ-016 On selection, the block SHALL latch req_data of the winner into tx_data, set grant_id, and move to ISSUE.
REQ-017 ISSUE lasts exactly one cycle: tx_start=1, req_ready[grant_id]=1, all other req_ready bits 0; next state WAIT_BUSY.
REQ-018 Request-to-tx_start latency SHALL be 1 cycle: valid sampled in cycle N gives tx_start in N+1.
REQ-019 WAIT_BUSY: on tx_busy=1 the block SHALL go to WAIT_DONE; after BUSY_TIMEOUT cycles without it, it SHALL set timeout_err and return to IDLE.
REQ-020 WAIT_DONE: on tx_busy=0 the block SHALL load rr_ptr with grant_id and return to IDLE.
REQ-021 The next grant SHALL occur no earlier than the IDLE cycle following the tx_busy fall, so at least 1 cycle separates consecutive tx_start pulses.
REQ-022 tx_data SHALL hold stable from ISSUE until the next selection.
REQ-023 Requests arriving or dropping outside IDLE SHALL be ignored; no request SHALL be queued internally.
REQ-024 If tx_busy is high in IDLE (foreign traffic), the block SHALL not grant until tx_busy is low.
REQ-025 On the timeout path rr_ptr SHALL also advance to grant_id, so a faulty requester cannot starve others.
REQ-026 Only rst SHALL clear timeout_err.
REQ-027 A single persistently-valid requester SHALL be granted on every arbitration.

Reset
REQ-028 Reset SHALL apply asynchronously, including mid-transfer: state=IDLE, tx_start=0, req_ready=0, tx_data=0x00, grant_id=0, active=0, timeout_err=0.
REQ-029 Reset SHALL set rr_ptr=NUM_REQ-1, so requester 0 has first priority after reset.
REQ-030 Reset SHALL clear the timeout counter.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2 bits) and default constants NUM_REQ=4 and BUSY_TIMEOUT=4.
REQ-032 Round-robin selection SHALL live in a combinational sub-module rr_select, with inputs req vector and rr_ptr and outputs winner index and any_req.

Verification
REQ-033 Single requester: req_valid=0001, data 0x55; -> tx_start and req_ready=0001 one cycle later, tx_data=0x55, grant_id=0.
REQ-034 Contention after reset: all four valid, data 0x10/0x21/0x32/0x43, transmitter model busy 100 cycles per byte; -> bytes in order 0x10, 0x21, 0x32, 0x43, one tx_start per tx_busy cycle.
REQ-035 Fairness wrap: requesters 3 and 0 persistently valid, last grant 3; -> grants alternate 0, 3, 0, 3.
REQ-036 Timeout: tx_busy held 0 after tx_start; -> timeout_err=1 after 4 cycles, return to IDLE, next grant goes to the next requester.
REQ-037 Reset mid-transfer: assert rst in WAIT_DONE; -> all outputs reach reset values immediately; after release, requester 0 wins first.
REQ-038 Foreign busy: tx_busy=1 while req_valid=0010; -> no tx_start until 1 cycle after tx_busy falls.
